// File: rtl/spreading_factors_pkg.sv
// Spreading-factor codes and DCSK receive-side shared types.
// Chips per half-bit are derived from the SF code via sf_to_chips.
package spreading_factors_pkg;

   typedef enum logic [1:0] {
      SF2  = 2'd0,
      SF4  = 2'd1,
      SF8  = 2'd2,
      SF16 = 2'd3
   } sf_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REF,
      ST_DATA,
      ST_DECIDE
   } demod_state_e;

   function automatic logic [4:0] sf_to_chips(input logic [1:0] sf);
      case (sf_e'(sf))
         SF2:     return 5'd2;
         SF4:     return 5'd4;
         SF8:     return 5'd8;
         default: return 5'd16;
      endcase
   endfunction

endpackage

// File: rtl/dcsk_demodulator_sipo.sv
// Serial-in collector: shifts decided bits MSB-first into a WIDTH-bit word
// and raises a one-cycle full flag after the WIDTH-th bit.
module sipo #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_arst_n,
   input  logic             clear,
   input  logic             shift,
   input  logic             data_in,
   output logic [WIDTH-1:0] word,
   output logic             full
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [CW-1:0] count;

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         word  <= '0;
         count <= '0;
         full  <= 1'b0;
      end else begin
         full <= 1'b0;
         if (clear) begin
            count <= '0;
         end else if (shift) begin
            word <= {word[WIDTH-2:0], data_in};
            if (count == CW'(WIDTH - 1)) begin
               count <= '0;
               full  <= 1'b1;
            end else begin
               count <= count + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/dcsk_demodulator.sv
// Serial DCSK receiver: reference-line correlation, majority decision per bit,
// word collection with valid/ready output. DCSK_DEMOD_SOFT_OUT_EN adds o_corr.
module dcsk_demodulator
   import spreading_factors_pkg::*;
#(
   parameter int unsigned MSG_WIDTH = 32
) (
   input  logic                 i_clk,
   input  logic                 i_arst_n,
   input  logic                 i_en,
   input  logic                 i_serial,
   input  logic [1:0]           i_spreading_factor,
   input  logic                 i_chip_idx_msb,
   output logic [MSG_WIDTH-1:0] o_msg,
   output logic                 o_msg_valid,
   input  logic                 i_msg_ready,
   output logic                 o_bit,
   output logic                 o_bit_valid,
   output logic                 o_sync_err,
`ifdef DCSK_DEMOD_SOFT_OUT_EN
   output logic [4:0]           o_corr,
`endif
   output logic                 o_overrun
);

   demod_state_e   state, state_nx;
   logic [15:0]    ref_line;
   logic           armed;
   logic [4:0]     n_chips;
   logic           tap;
   logic           agree_chip;
   logic [4:0]     agree, agree_nx;
   logic [4:0]     chip_cnt, chips_nx;
   logic [5:0]     twice_agree;
   logic           decide;
   logic           len_ok;
   logic           decided_bit;
   logic           emit;
   logic           sync_nx;
   logic [MSG_WIDTH-1:0] word;
   logic           word_full;

   assign n_chips    = sf_to_chips(i_spreading_factor);
   assign tap        = ref_line[4'(n_chips - 5'd1)];
   assign agree_chip = ~(i_serial ^ tap);

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         ref_line <= '0;
         armed    <= 1'b1;
      end else begin
         ref_line <= {ref_line[14:0], i_serial};
         armed    <= i_chip_idx_msb;
      end
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) state <= ST_IDLE;
      else           state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (!i_en) begin
         state_nx = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:   if (!i_chip_idx_msb && armed) state_nx = ST_REF;
            ST_REF:    if (i_chip_idx_msb) state_nx = ST_DATA;
            ST_DATA:   if (!i_chip_idx_msb) state_nx = ST_DECIDE;
            ST_DECIDE: state_nx = ST_REF;
            default:   state_nx = ST_IDLE;
         endcase
      end
   end

   // The decision is evaluated on the DATA->DECIDE transition so that the
   // registered bit outputs are visible during the DECIDE cycle itself.
   assign decide      = i_en && (state == ST_DATA) && !i_chip_idx_msb;
   assign len_ok      = (chip_cnt == n_chips);
   assign twice_agree = {agree, 1'b0};
   assign decided_bit = twice_agree > {1'b0, n_chips};
   assign emit        = decide && len_ok;

`ifdef DCSK_DEMOD_SOFT_OUT_EN
   logic tie;
   assign tie = (twice_agree == {1'b0, n_chips});
`endif

   always_comb begin
      agree_nx = agree;
      chips_nx = chip_cnt;
      case (state)
         ST_REF: begin
            agree_nx = i_chip_idx_msb ? {4'd0, agree_chip} : 5'd0;
            chips_nx = i_chip_idx_msb ? 5'd1 : 5'd0;
         end
         ST_DATA: begin
            if (i_chip_idx_msb) begin
               if (chip_cnt != 5'd31) chips_nx = chip_cnt + 5'd1;
               if (agree_chip && (agree != 5'd31)) agree_nx = agree + 5'd1;
            end
         end
         default: begin
            agree_nx = '0;
            chips_nx = '0;
         end
      endcase
      if (!i_en) begin
         agree_nx = '0;
         chips_nx = '0;
      end
`ifdef DCSK_DEMOD_SOFT_OUT_EN
      sync_nx = decide && (!len_ok || tie);
`else
      sync_nx = decide && !len_ok;
`endif
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         agree       <= '0;
         chip_cnt    <= '0;
         o_bit       <= 1'b0;
         o_bit_valid <= 1'b0;
         o_sync_err  <= 1'b0;
`ifdef DCSK_DEMOD_SOFT_OUT_EN
         o_corr      <= '0;
`endif
      end else begin
         agree       <= agree_nx;
         chip_cnt    <= chips_nx;
         o_bit_valid <= emit;
         o_sync_err  <= sync_nx;
         if (emit) begin
            o_bit <= decided_bit;
`ifdef DCSK_DEMOD_SOFT_OUT_EN
            o_corr <= agree;
`endif
         end
      end
   end

   sipo #(
      .WIDTH (MSG_WIDTH)
   ) u_sipo (
      .i_clk    (i_clk),
      .i_arst_n (i_arst_n),
      .clear    (!i_en),
      .shift    (emit),
      .data_in  (decided_bit),
      .word     (word),
      .full     (word_full)
   );

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         o_msg       <= '0;
         o_msg_valid <= 1'b0;
         o_overrun   <= 1'b0;
      end else begin
         o_overrun <= 1'b0;
         if (word_full) begin
            if (o_msg_valid && !i_msg_ready) begin
               o_overrun <= 1'b1;
            end else begin
               o_msg       <= word;
               o_msg_valid <= 1'b1;
            end
         end else if (o_msg_valid && i_msg_ready) begin
            o_msg_valid <= 1'b0;
         end
      end
   end

endmodule
